// File: rtl/uart_rx_ovs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared encodings for the oversampling UART receiver: parity
//             mode codes, receive FSM states and error-flag bit positions.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // parity_mode encodings; 2'b11 is not listed and behaves as PAR_NONE
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Bit positions inside the 3-bit per-word error field
    localparam int ERR_PAR = 0;
    localparam int ERR_FRM = 1;
    localparam int ERR_BRK = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP1   = 3'd4,
        ST_STOP2   = 3'd5,
        ST_WAIT_HI = 3'd6
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : First-word-fall-through FIFO holding received words plus their
//             error flags. Reports level/full/empty and a sticky overrun.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             i_push, i_wdata     - write request and word
//             i_pop               - pop head (ignored when empty)
//             o_rdata             - head word, zero while empty
//             o_empty, o_full     - occupancy flags
//             o_level             - number of stored words
//             o_overrun           - sticky: a push was dropped
//             i_overrun_clr       - clears o_overrun (a new drop wins)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH   = 12,
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               i_push,
    input  wire logic [WIDTH-1:0]   i_wdata,
    input  wire logic               i_pop,
    output logic      [WIDTH-1:0]   o_rdata,
    output logic                    o_empty,
    output logic                    o_full,
    output logic      [LEVEL_W-1:0] o_level,
    output logic                    o_overrun,
    input  wire logic               i_overrun_clr
);

    localparam int c_ptr_w = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [c_ptr_w:0] r_wr_ptr;
    logic [c_ptr_w:0] r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_overrun;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;
    logic             w_drop;
    logic [c_ptr_w:0] w_diff;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds in that case.
    assign w_wr    = i_push & (~w_full | w_pop);
    assign w_drop  = i_push & w_full & ~w_pop;
    assign w_diff  = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (c_ptr_w + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_ptr_w + 1)'(1);
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= i_wdata;
        end
    end

    assign o_rdata   = w_empty ? '0 : r_mem[r_rd_ptr[c_ptr_w-1:0]];
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_level   = LEVEL_W'(w_diff);
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ovs
//  Purpose  : Oversampling UART receiver (5..DATA_W_MAX data bits, optional
//             even/odd parity, 1 or 2 stop bits) with a receive FIFO and
//             per-word parity/framing/break flags.
//  Ports    : PCLK, PRESETn                - clock, async active-low reset
//             en                           - receiver enable
//             baud_div                     - PCLK cycles per tick, minus 1
//             data_bits, parity_mode,
//             stop_bits                    - frame format, latched at start
//             rxd                          - serial input, idle high
//             rd_en, rd_data, rd_err       - FIFO pop / head word / flags
//             empty, full, level           - FIFO status
//             overrun, overrun_clr         - sticky drop flag and clear
//             busy                         - receiver not idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int DATA_W_MAX = 9,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV_W = 16
) (
    input  wire logic                            PCLK,
    input  wire logic                            PRESETn,
    input  wire logic                            en,
    input  wire logic [BAUD_DIV_W-1:0]           baud_div,
    input  wire logic [3:0]                      data_bits,
    input  wire logic [1:0]                      parity_mode,
    input  wire logic                            stop_bits,
    input  wire logic                            rxd,
    input  wire logic                            rd_en,
    output logic      [DATA_W_MAX-1:0]           rd_data,
    output logic      [2:0]                      rd_err,
    output logic                                 empty,
    output logic                                 full,
    output logic      [$clog2(FIFO_DEPTH+1)-1:0] level,
    output logic                                 overrun,
    input  wire logic                            overrun_clr,
    output logic                                 busy
);

    localparam int              c_cnt_w    = $clog2(OVS);
    localparam logic [c_cnt_w-1:0] c_ovs_last = c_cnt_w'(OVS - 1);
    localparam logic [c_cnt_w-1:0] c_ovs_mid  = c_cnt_w'(OVS / 2 - 1);
    localparam logic [3:0]      c_dw_max   = 4'(DATA_W_MAX);

    logic                  r_rxd_meta;
    logic                  r_rxs;
    logic                  r_rxs_prev;
    logic [BAUD_DIV_W-1:0] r_baud_cnt;
    rx_state_e             r_state;
    logic [c_cnt_w-1:0]    r_ovs_cnt;
    logic [3:0]            r_bit_cnt;
    logic [DATA_W_MAX-1:0] r_shift;
    logic                  r_par_acc;
    logic                  r_par_err;
    logic                  r_frm;
    logic                  r_all_zero;
    logic [3:0]            r_cfg_bits;
    logic [1:0]            r_cfg_par;
    logic                  r_cfg_stop2;

    rx_state_e             w_next;
    logic                  w_tick;
    logic                  w_fall;
    logic                  w_sample;
    logic                  w_start;
    logic                  w_push;
    logic                  w_frm_final;
    logic                  w_brk;
    logic [3:0]            w_bits_clamped;
    logic [1:0]            w_par_norm;
    logic [2:0]            w_err;

    // ---------------- input synchroniser ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rxd_meta <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxs      <= r_rxd_meta;
            r_rxs_prev <= r_rxs;
        end
    end

    // ---------------- oversample tick generator ----------------
    assign w_tick = en && (r_baud_cnt == '0);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_baud_cnt <= '0;
        end else if (!en || (r_baud_cnt == '0)) begin
            r_baud_cnt <= baud_div;
        end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_DIV_W'(1);
        end
    end

    // ---------------- frame decode ----------------
    assign w_bits_clamped = ((data_bits < 4'd5) || (data_bits > c_dw_max)) ? c_dw_max : data_bits;
    assign w_par_norm     = ((parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD)) ? parity_mode : PAR_NONE;
    assign w_fall         = r_rxs_prev & ~r_rxs;
    // The start bit is checked half a bit in; every later sample is a full
    // bit period after the previous one, landing on bit centres.
    assign w_sample       = w_tick && (r_ovs_cnt == ((r_state == ST_START) ? c_ovs_mid : c_ovs_last));
    // Evaluated at the final stop sample, folding in the current rxs
    assign w_frm_final    = r_frm | ~r_rxs;
    assign w_brk          = r_all_zero & ~r_rxs;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_push  = 1'b0;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_next  = ST_START;
                    w_start = 1'b1;
                end
            end
            ST_START: begin
                if (w_sample) begin
                    w_next = r_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_sample && (r_bit_cnt == r_cfg_bits - 4'd1)) begin
                    w_next = (r_cfg_par != PAR_NONE) ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (w_sample) begin
                    w_next = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (w_sample) begin
                    if (r_cfg_stop2) begin
                        w_next = ST_STOP2;
                    end else begin
                        w_push = 1'b1;
                        w_next = w_frm_final ? ST_WAIT_HI : ST_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (w_sample) begin
                    w_push = 1'b1;
                    w_next = w_frm_final ? ST_WAIT_HI : ST_IDLE;
                end
            end
            ST_WAIT_HI: begin
                // A held-low line must not restart a frame until it idles
                if (r_rxs) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (!en) begin
            w_next  = ST_IDLE;
            w_push  = 1'b0;
            w_start = 1'b0;
        end
    end

    // ---------------- receive datapath ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_ovs_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frm       <= 1'b0;
            r_all_zero  <= 1'b1;
            r_cfg_bits  <= c_dw_max;
            r_cfg_par   <= PAR_NONE;
            r_cfg_stop2 <= 1'b0;
        end else if (w_start) begin
            r_ovs_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frm       <= 1'b0;
            r_all_zero  <= 1'b1;
            r_cfg_bits  <= w_bits_clamped;
            r_cfg_par   <= w_par_norm;
            r_cfg_stop2 <= stop_bits;
        end else if (w_tick && (r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2})) begin
            r_ovs_cnt <= w_sample ? '0 : r_ovs_cnt + c_cnt_w'(1);
            if (w_sample) begin
                case (r_state)
                    ST_DATA: begin
                        r_shift[r_bit_cnt] <= r_rxs;
                        r_par_acc          <= r_par_acc ^ r_rxs;
                        r_all_zero         <= r_all_zero & ~r_rxs;
                        r_bit_cnt          <= r_bit_cnt + 4'd1;
                    end
                    ST_PARITY: begin
                        // Even: data^parity must be 0; odd: must be 1
                        r_par_err  <= (r_par_acc ^ r_rxs) != (r_cfg_par == PAR_ODD);
                        r_all_zero <= r_all_zero & ~r_rxs;
                    end
                    ST_STOP1: begin
                        r_frm      <= ~r_rxs;
                        r_all_zero <= r_all_zero & ~r_rxs;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_err          = 3'b000;
        w_err[ERR_PAR] = r_par_err;
        w_err[ERR_FRM] = w_frm_final;
        w_err[ERR_BRK] = w_brk;
    end

    // ---------------- receive FIFO ----------------
    logic [DATA_W_MAX+2:0] w_fifo_rdata;

    uart_rx_fifo #(
        .WIDTH   (DATA_W_MAX + 3),
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W ($clog2(FIFO_DEPTH + 1))
    ) u_fifo (
        .clk           (PCLK),
        .rst_n         (PRESETn),
        .i_push        (w_push),
        .i_wdata       ({w_err, r_shift}),
        .i_pop         (rd_en),
        .o_rdata       (w_fifo_rdata),
        .o_empty       (empty),
        .o_full        (full),
        .o_level       (level),
        .o_overrun     (overrun),
        .i_overrun_clr (overrun_clr)
    );

    assign rd_data = w_fifo_rdata[DATA_W_MAX-1:0];
    assign rd_err  = w_fifo_rdata[DATA_W_MAX+2:DATA_W_MAX];
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire
